// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: WB pipe result, multi-cycle result handshake,
// the registered write port, the stall request and the pending-write mask.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                    pipeWrEn;
  logic [ADDR_W-1:0]       pipeAddr;
  logic [DATA_W-1:0]       pipeData;
  logic                    mcValid;
  logic [ADDR_W-1:0]       mcAddr;
  logic [DATA_W-1:0]       mcData;
  logic                    mcReady;
  logic                    rfWrEn;
  logic [ADDR_W-1:0]       rfAddr;
  logic [DATA_W-1:0]       rfData;
  logic                    stallPipe;
  logic [(1<<ADDR_W)-1:0]  pendMask;

  modport slave (
    input  pipeWrEn, pipeAddr, pipeData, mcValid, mcAddr, mcData,
    output mcReady, rfWrEn, rfAddr, rfData, stallPipe, pendMask
  );

  modport master (
    output pipeWrEn, pipeAddr, pipeData, mcValid, mcAddr, mcData,
    input  mcReady, rfWrEn, rfAddr, rfData, stallPipe, pendMask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB pipe and a queued multi-cycle unit.
// Optional macro WB_ARB_BYPASS_EN lets a multi-cycle result skip an empty queue.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int NREG = 1 << ADDR_W;

  logic              live_q [DEPTH];
  logic              live_d [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              full, empty, stall, pipe_gnt, pop, push, bypass;
  logic [DEPTH-1:0]  occ;
  logic [NREG-1:0]   pend;
  logic [PW-1:0]     off;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    stall    = full || (!empty && (starve_q >= SW'(STARVE_LIMIT)));
    pipe_gnt = !stall && bus.pipeWrEn;
    pop      = stall || (!bus.pipeWrEn && !empty);
`ifdef WB_ARB_BYPASS_EN
    bypass   = empty && !bus.pipeWrEn && bus.mcValid;
`else
    bypass   = 1'b0;
`endif
    push     = bus.mcValid && !full && !bypass;

    // An entry is occupied when its distance from the read pointer is below count.
    occ  = '0;
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PW'(i) - rd_ptr_q;
      occ[i] = (CW'(off) < count_q);
      if (occ[i] && live_q[i]) pend[addr_q[i]] = 1'b1;
    end
  end

  always_comb begin
    live_d = live_q;
    addr_d = addr_q;
    data_d = data_q;
    // The pipe write is younger, so it kills older queued writes to the same register.
    if (pipe_gnt) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == bus.pipeAddr) live_d[i] = 1'b0;
      end
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q] = bus.mcAddr;
      data_d[wr_ptr_q] = bus.mcData;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    starve_d = starve_q;
    if (empty || pop) starve_d = '0;
    else if (starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);

    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pipe_gnt) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.pipeAddr;
      rf_data_d = bus.pipeData;
    end else if (pop) begin
      // A cancelled head frees its slot without touching the register file.
      rf_we_d = live_q[rd_ptr_q];
      if (live_q[rd_ptr_q]) begin
        rf_addr_d = addr_q[rd_ptr_q];
        rf_data_d = data_q[rd_ptr_q];
      end
    end else if (bypass) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.mcAddr;
      rf_data_d = bus.mcData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      live_q    <= live_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Payload storage is qualified by live/count, so it needs no reset.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign bus.mcReady   = !full;
  assign bus.stallPipe = stall;
  assign bus.pendMask  = pend;
  assign bus.rfWrEn    = rf_we_q;
  assign bus.rfAddr    = rf_addr_q;
  assign bus.rfData    = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipe writes, queue drain, full stall,
// starvation, WAW cancellation and asynchronous reset with a full queue.
module tb_wb_port_arbiter;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  wb_port_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipeWrEn = 1'b0; bus.pipeAddr = '0; bus.pipeData = '0;
    bus.mcValid  = 1'b0; bus.mcAddr   = '0; bus.mcData   = '0;
  endtask

  task automatic chk_rf(string name, logic we, logic [2:0] a, logic [15:0] d);
    total++;
    if (bus.rfWrEn !== we || (we && (bus.rfAddr !== a || bus.rfData !== d))) begin
      bad++;
      $display("FAIL %s: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
               name, bus.rfWrEn, bus.rfAddr, bus.rfData, we, a, d);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    total++; if (bus.rfWrEn !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.rfWrEn); end
    total++; if (bus.rfAddr !== 3'd0 || bus.rfData !== 16'h0) begin bad++; $display("FAIL reset_rf: got %0d/%h want 0/0000", bus.rfAddr, bus.rfData); end
    total++; if (bus.mcReady !== 1'b1 || bus.stallPipe !== 1'b0) begin bad++; $display("FAIL reset_ctl: got ready=%b stall=%b want 1/0", bus.mcReady, bus.stallPipe); end
    total++; if (bus.pendMask !== 8'h00) begin bad++; $display("FAIL reset_pend: got %h want 00", bus.pendMask); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pipe();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd3; bus.pipeData = 16'h0003;
    tick();
    chk_rf("pipe_write", 1'b1, 3'd3, 16'h0003);
    bus.pipeWrEn = 1'b0;
    tick();
    chk_rf("pipe_idle", 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_queue_drain();
    bus.mcValid = 1'b1; bus.mcAddr = 3'd5; bus.mcData = 16'h1234;
    tick();
    bus.mcValid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    chk_rf("drain_bypass", 1'b1, 3'd5, 16'h1234);
    total++; if (bus.pendMask !== 8'h00) begin bad++; $display("FAIL drain_bypass_pend: got %h want 00", bus.pendMask); end
    tick();
    chk_rf("drain_after", 1'b0, 3'd0, 16'h0);
`else
    total++; if (bus.pendMask !== 8'h20) begin bad++; $display("FAIL drain_pend: got %h want 20", bus.pendMask); end
    chk_rf("drain_wait", 1'b0, 3'd0, 16'h0);
    tick();
    chk_rf("drain_write", 1'b1, 3'd5, 16'h1234);
    total++; if (bus.pendMask !== 8'h00) begin bad++; $display("FAIL drain_pend_clr: got %h want 00", bus.pendMask); end
`endif
    tick();
  endtask

  task automatic test_full_stall();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd1; bus.pipeData = 16'h0101;
    bus.mcValid  = 1'b1; bus.mcAddr   = 3'd4; bus.mcData   = 16'h4444;
    tick();
    chk_rf("full_pipe1", 1'b1, 3'd1, 16'h0101);
    bus.mcAddr = 3'd6; bus.mcData = 16'h6666;
    tick();
    bus.mcValid = 1'b0;
    chk_rf("full_pipe2", 1'b1, 3'd1, 16'h0101);
    total++; if (bus.mcReady !== 1'b0 || bus.stallPipe !== 1'b1) begin bad++; $display("FAIL full_flags: got ready=%b stall=%b want 0/1", bus.mcReady, bus.stallPipe); end
    total++; if (bus.pendMask !== 8'h50) begin bad++; $display("FAIL full_pend: got %h want 50", bus.pendMask); end
    tick();
    chk_rf("full_popA", 1'b1, 3'd4, 16'h4444);
    total++; if (bus.stallPipe !== 1'b0 || bus.pendMask !== 8'h40) begin bad++; $display("FAIL full_afterA: got stall=%b pend=%h want 0/40", bus.stallPipe, bus.pendMask); end
    // B starves behind the held pipe write until the limit forces it out.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rf("full_pipe_wait", 1'b1, 3'd1, 16'h0101);
      total++; if (bus.stallPipe !== (k == 3)) begin bad++; $display("FAIL full_starve_k%0d: got stall=%b want %b", k, bus.stallPipe, (k == 3)); end
    end
    tick();
    chk_rf("full_popB", 1'b1, 3'd6, 16'h6666);
    total++; if (bus.stallPipe !== 1'b0 || bus.pendMask !== 8'h00) begin bad++; $display("FAIL full_afterB: got stall=%b pend=%h want 0/00", bus.stallPipe, bus.pendMask); end
    tick();
    chk_rf("full_pipe_resume", 1'b1, 3'd1, 16'h0101);
    bus.pipeWrEn = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd7; bus.pipeData = 16'h0700;
    bus.mcValid  = 1'b1; bus.mcAddr   = 3'd3; bus.mcData   = 16'h3333;
    tick();
    bus.mcValid = 1'b0;
    total++; if (bus.stallPipe !== 1'b0) begin bad++; $display("FAIL starve_start: got stall=%b want 0", bus.stallPipe); end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rf("starve_pipe", 1'b1, 3'd7, 16'h0700);
      total++; if (bus.stallPipe !== (k == 3)) begin bad++; $display("FAIL starve_k%0d: got stall=%b want %b", k, bus.stallPipe, (k == 3)); end
    end
    tick();
    chk_rf("starve_head", 1'b1, 3'd3, 16'h3333);
    total++; if (bus.stallPipe !== 1'b0) begin bad++; $display("FAIL starve_release: got stall=%b want 0", bus.stallPipe); end
    tick();
    chk_rf("starve_pipe_done", 1'b1, 3'd7, 16'h0700);
    bus.pipeWrEn = 1'b0;
    tick();
  endtask

  task automatic test_waw_cancel();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd0; bus.pipeData = 16'h0000;
    bus.mcValid  = 1'b1; bus.mcAddr   = 3'd2; bus.mcData   = 16'hAAAA;
    tick();
    bus.mcValid = 1'b0;
    bus.pipeAddr = 3'd2; bus.pipeData = 16'h5555;
    total++; if (bus.pendMask !== 8'h04) begin bad++; $display("FAIL waw_pend_set: got %h want 04", bus.pendMask); end
    tick();
    bus.pipeWrEn = 1'b0;
    chk_rf("waw_pipe", 1'b1, 3'd2, 16'h5555);
    total++; if (bus.pendMask !== 8'h00) begin bad++; $display("FAIL waw_pend_clr: got %h want 00", bus.pendMask); end
    tick();
    chk_rf("waw_cancel_pop", 1'b0, 3'd0, 16'h0);
    total++; if (bus.rfData !== 16'h5555 || bus.mcReady !== 1'b1) begin bad++; $display("FAIL waw_keep: got data=%h ready=%b want 5555/1", bus.rfData, bus.mcReady); end
    tick();
  endtask

  task automatic test_waw_same_cycle();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd5; bus.pipeData = 16'h0505;
    bus.mcValid  = 1'b1; bus.mcAddr   = 3'd5; bus.mcData   = 16'h5A5A;
    tick();
    idle_inputs();
    chk_rf("same_pipe", 1'b1, 3'd5, 16'h0505);
    total++; if (bus.pendMask !== 8'h20) begin bad++; $display("FAIL same_pend: got %h want 20", bus.pendMask); end
    tick();
    chk_rf("same_pop", 1'b1, 3'd5, 16'h5A5A);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.pipeWrEn = 1'b1; bus.pipeAddr = 3'd1; bus.pipeData = 16'h1111;
    bus.mcValid  = 1'b1; bus.mcAddr   = 3'd4; bus.mcData   = 16'hC4C4;
    tick();
    bus.mcAddr = 3'd6; bus.mcData = 16'hC6C6;
    tick();
    idle_inputs();
    total++; if (bus.pendMask !== 8'h50 || bus.mcReady !== 1'b0) begin bad++; $display("FAIL rstmid_pre: got pend=%h ready=%b want 50/0", bus.pendMask, bus.mcReady); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.rfWrEn !== 1'b0 || bus.mcReady !== 1'b1 || bus.pendMask !== 8'h00 || bus.stallPipe !== 1'b0) begin
      bad++; $display("FAIL rstmid_async: got we=%b ready=%b pend=%h stall=%b want 0/1/00/0", bus.rfWrEn, bus.mcReady, bus.pendMask, bus.stallPipe);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rf("rstmid_no_write", 1'b0, 3'd0, 16'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe();
    test_queue_drain();
    test_full_stall();
    test_starvation();
    test_waw_cancel();
    test_waw_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and scheduler for the single register-file write port of the 16-bit processor. It sits after the WB stage and shares the port between the in-order pipeline result (WB output) and a multi-cycle execution unit. Multi-cycle results are held in a small queue, and the pipeline is stalled when those results would otherwise starve. The block also exposes a pending-write mask to the hazard logic.

## Interface
Parameters:
- DATA_W, 16, write data width
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 2, multi-cycle result queue entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a queued head may wait before stalling the pipe

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- pipeWrEn  in  1  WB stage writes this cycle (RegWrite)
- pipeAddr  in  ADDR_W  WB destination register
- pipeData  in  DATA_W  WB result (outputWB)
- mcValid  in  1  multi-cycle result offered
- mcAddr  in  ADDR_W  multi-cycle destination
- mcData  in  DATA_W  multi-cycle result
- mcReady  out  1  queue accepts; transfer when mcValid && mcReady
- rfWrEn  out  1  registered register-file write enable
- rfAddr  out  ADDR_W  registered write address
- rfData  out  DATA_W  registered write data
- stallPipe  out  1  freeze pipeline; WB must hold pipeWrEn/pipeAddr/pipeData
- pendMask  out  2^ADDR_W  bit r set if a live queued entry targets r

## Operation
- Queue: circular FIFO, DEPTH entries, each {live, addr, data}; wr/rd pointers plus count.
- mcReady = (count != DEPTH), combinational.
- Grant each cycle, in priority order:
  - if stallPipe, the queue head gets the port (pipeWrEn ignored);
  - else if pipeWrEn, the pipe gets the port;
  - else if the queue is non-empty, the queue head gets the port.
- stallPipe = full || (nonEmpty && starveCnt ≥ STARVE_LIMIT), combinational from state.
- starveCnt: increments each cycle the queue is non-empty and not popped; clears on pop or when empty; saturates at STARVE_LIMIT.
- Pop of a head with live=0 (cancelled): rfWrEn=0 that cycle, the slot is freed, and it counts as a pop.
- WAW rule: a granted pipe write to register r clears live on every queued entry with addr==r. The pipeline write is architecturally younger. An entry pushed in the same cycle is not cancelled.
- Simultaneous push and pop: both occur and count is unchanged. Push is impossible when full.
- pendMask = OR over occupied entries with live=1 of onehot(addr).

## Timing
- Reset values: rfWrEn=0, rfAddr=0, rfData=0, queue empty, starveCnt=0. Outputs during and after reset: mcReady=1, stallPipe=0, pendMask=0.
- Pipe write: pipeWrEn at edge N → rfWrEn/rfAddr/rfData valid after edge N+1 (1-cycle latency).
- Queued write: pushed at edge N → earliest granted in cycle N+1 → on the port after edge N+2 (2-cycle latency).
- A result is never lost, duplicated or reordered among queue entries.
- Reset mid-operation: all queued entries are discarded, and no write is issued for them.

## Configuration
- WB_ARB_BYPASS_EN defined: when the queue is empty, pipeWrEn=0 and mcValid=1, the multi-cycle result skips the queue and is written on the port after the next edge (1-cycle latency). It is not pushed, and pendMask stays 0 for it.
- Undefined: every multi-cycle result passes through the queue (2-cycle latency).

## Test plan
- Reset: assert reset asynchronously mid-cycle with 2 entries queued → rfWrEn=0, mcReady=1, pendMask=0 immediately, and no later write of those entries.
- Pipe only: pipeWrEn=1, pipeAddr=3, pipeData=0x0003 → next cycle rfWrEn=1, rfAddr=3, rfData=0x0003.
- Queue drain: mcValid push (addr 5, 0x1234) with pipe idle → pendMask=0x20, and the port writes 5/0x1234 two edges after the push (one edge with WB_ARB_BYPASS_EN).
- Full stall: push 2 entries while pipeWrEn=1 continuously → mcReady=0 and stallPipe=1. Both entries drain in order, then stallPipe drops and the held pipe write completes.
- Starvation: 1 queued entry with pipeWrEn=1 for 4 cycles → stallPipe=1 on cycle 5, head written, then stallPipe=0.
- WAW cancel: queue (addr 2, 0xAAAA), then pipe writes addr 2, 0x5555 → pendMask bit2 clears, the pop produces rfWrEn=0, and the register keeps 0x5555.
